// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if -- signal bundle between the instruction fetch stage, the
// instruction memory and the decode stage.
//
//   inst_ce / inst_addr / inst_data : instruction memory port (combinational read)
//   br_valid / br_target            : branch/jump redirect request from decode
//   flush / flush_pc                : exception / ERET restart request
//   id_ready                        : decode consumes the IF/ID register
//   id_valid / id_pc / id_inst /
//   id_adel                         : IF/ID register contents
//
// Modports:
//   master : the fetch stage (drives memory request and IF/ID register)
//   slave  : the environment (memory, decode, exception unit)
// ---------------------------------------------------------------------------
interface if_fetch_if;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        br_valid;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  modport master (
    output inst_ce, inst_addr, id_valid, id_pc, id_inst, id_adel,
    input  inst_data, br_valid, br_target, flush, flush_pc, id_ready
  );

  modport slave (
    input  inst_ce, inst_addr, id_valid, id_pc, id_inst, id_adel,
    output inst_data, br_valid, br_target, flush, flush_pc, id_ready
  );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with one-cycle fetch-to-IF/ID latency,
// a branch delay slot, a pending-redirect register for branches that arrive
// during a decode stall, and a top-priority flush path.
//
// Parameters:
//   RESET_PC : first fetch address after reset
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : if_fetch_if.master (memory port, redirect/flush inputs, IF/ID)
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  if_fetch_if.master bus
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic        id_valid_r;
  logic        id_valid_next_s;
  logic [31:0] id_pc_r;
  logic [31:0] id_pc_next_s;
  logic [31:0] id_inst_r;
  logic [31:0] id_inst_next_s;
  logic        id_adel_r;
  logic        id_adel_next_s;
  logic        pend_valid_r;
  logic        pend_valid_next_s;
  logic [31:0] pend_target_r;
  logic [31:0] pend_target_next_s;

  logic        aligned_s;
  logic        adv_s;

  assign aligned_s = (pc_r[1:0] == 2'b00);
  assign adv_s     = (state_r == RUN) && (!id_valid_r || bus.id_ready);

  // Memory request and IF/ID outputs come straight from registers.
  assign bus.inst_ce   = (state_r == RUN) && aligned_s;
  assign bus.inst_addr = pc_r;
  assign bus.id_valid  = id_valid_r;
  assign bus.id_pc     = id_pc_r;
  assign bus.id_inst   = id_inst_r;
  assign bus.id_adel   = id_adel_r;

  // Next-state and datapath decisions; every register holds unless updated.
  always_comb begin
    state_next_s       = state_r;
    pc_next_s          = pc_r;
    id_valid_next_s    = id_valid_r;
    id_pc_next_s       = id_pc_r;
    id_inst_next_s     = id_inst_r;
    id_adel_next_s     = id_adel_r;
    pend_valid_next_s  = pend_valid_r;
    pend_target_next_s = pend_target_r;

    if (bus.flush) begin
      // Flush beats everything: restart, drop the live entry and any redirect.
      state_next_s      = RUN;
      pc_next_s         = bus.flush_pc;
      id_valid_next_s   = 1'b0;
      pend_valid_next_s = 1'b0;
    end else begin
      case (state_r)
        BOOT:    state_next_s = RUN;
        RUN:     state_next_s = RUN;
        default: state_next_s = BOOT;
      endcase

      if (adv_s) begin
        id_valid_next_s = 1'b1;
        id_pc_next_s    = pc_r;
        id_inst_next_s  = aligned_s ? bus.inst_data : 32'h0000_0000;
        id_adel_next_s  = !aligned_s;
        // Wraps naturally modulo 2^32.
        pc_next_s       = pend_valid_r ? pend_target_r : (pc_r + 32'd4);
      end else begin
        // Only BOOT can see a consumed entry without advancing.
        id_valid_next_s = ((state_r == BOOT) && bus.id_ready) ? 1'b0 : id_valid_r;
      end

      // A redirect is always parked in the pending register first, so the
      // word fetched in the following cycle (the delay slot) is delivered
      // normally and the target is fetched on the advance after that. A newer
      // request overwrites an older one that has not yet been consumed.
      if (bus.br_valid) begin
        pend_valid_next_s  = 1'b1;
        pend_target_next_s = bus.br_target;
      end else begin
        pend_valid_next_s  = adv_s ? 1'b0 : pend_valid_r;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC, IF/ID and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      id_valid_r    <= 1'b0;
      id_pc_r       <= 32'h0000_0000;
      id_inst_r     <= 32'h0000_0000;
      id_adel_r     <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_target_r <= 32'h0000_0000;
    end else begin
      pc_r          <= pc_next_s;
      id_valid_r    <= id_valid_next_s;
      id_pc_r       <= id_pc_next_s;
      id_inst_r     <= id_inst_next_s;
      id_adel_r     <= id_adel_next_s;
      pend_valid_r  <= pend_valid_next_s;
      pend_target_r <= pend_target_next_s;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed self-checking bench for if_fetch.
// Instruction memory returns word i = 32'h1000_0000 + i for byte address 4*i.
// ---------------------------------------------------------------------------
module tb_if_fetch;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational instruction memory.
  assign bus.inst_data = 32'h1000_0000 + {2'b00, bus.inst_addr[31:2]};

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the IF/ID register holds a live entry with the given pc/word/adel.
  task automatic chk_id(input string tag, input logic [31:0] pc,
                        input logic [31:0] inst, input logic adel);
    chk({tag, "_valid"}, {31'd0, bus.id_valid}, 32'd1);
    chk({tag, "_pc"}, bus.id_pc, pc);
    chk({tag, "_inst"}, bus.id_inst, inst);
    chk({tag, "_adel"}, {31'd0, bus.id_adel}, {31'd0, adel});
  endtask

  // Directed sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.br_valid = 1'b0;
    bus.br_target = 32'h0000_0000;
    bus.flush = 1'b0;
    bus.flush_pc = 32'h0000_0000;
    bus.id_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_ce", {31'd0, bus.inst_ce}, 32'd0);
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_addr", bus.inst_addr, 32'h0000_0000);
    chk("rst_pc", bus.id_pc, 32'h0000_0000);
    chk("rst_inst", bus.id_inst, 32'h0000_0000);
    chk("rst_adel", {31'd0, bus.id_adel}, 32'd0);

    // Reset release: one BOOT cycle, then sequential fetch
    rst = 1'b0;
    chk("boot_ce", {31'd0, bus.inst_ce}, 32'd0);
    tick();
    chk("run_ce", {31'd0, bus.inst_ce}, 32'd1);
    chk("run_addr", bus.inst_addr, 32'h0000_0000);
    chk("run_valid0", {31'd0, bus.id_valid}, 32'd0);
    tick();
    chk_id("seq0", 32'h0000_0000, 32'h1000_0000, 1'b0);
    tick();
    chk_id("seq4", 32'h0000_0004, 32'h1000_0001, 1'b0);
    chk("seq_addr8", bus.inst_addr, 32'h0000_0008);

    // Branch with delay slot: 8, 12, 0x40, 0x44
    bus.br_valid = 1'b1;
    bus.br_target = 32'h0000_0040;
    tick();
    bus.br_valid = 1'b0;
    chk_id("br8", 32'h0000_0008, 32'h1000_0002, 1'b0);
    tick();
    chk_id("br_slot", 32'h0000_000C, 32'h1000_0003, 1'b0);
    tick();
    chk_id("br_tgt", 32'h0000_0040, 32'h1000_0010, 1'b0);
    tick();
    chk_id("br_tgt4", 32'h0000_0044, 32'h1000_0011, 1'b0);

    // Stall of three cycles with a branch pulsed mid-stall
    bus.id_ready = 1'b0;
    tick();
    bus.br_valid = 1'b1;
    bus.br_target = 32'h0000_0080;
    tick();
    bus.br_valid = 1'b0;
    tick();
    chk_id("stall_hold", 32'h0000_0044, 32'h1000_0011, 1'b0);
    chk("stall_addr", bus.inst_addr, 32'h0000_0048);
    chk("stall_ce", {31'd0, bus.inst_ce}, 32'd1);
    bus.id_ready = 1'b1;
    tick();
    chk_id("stall_rel", 32'h0000_0048, 32'h1000_0012, 1'b0);
    tick();
    chk_id("stall_tgt", 32'h0000_0080, 32'h1000_0020, 1'b0);

    // Flush coincident with a branch and a stall
    bus.flush = 1'b1;
    bus.flush_pc = 32'h0000_0180;
    bus.br_valid = 1'b1;
    bus.br_target = 32'h0000_0300;
    bus.id_ready = 1'b0;
    tick();
    bus.flush = 1'b0;
    bus.br_valid = 1'b0;
    bus.id_ready = 1'b1;
    chk("fl_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("fl_addr", bus.inst_addr, 32'h0000_0180);
    tick();
    chk_id("fl_first", 32'h0000_0180, 32'h1000_0060, 1'b0);
    tick();
    chk_id("fl_second", 32'h0000_0184, 32'h1000_0061, 1'b0);
    tick();
    chk_id("fl_third", 32'h0000_0188, 32'h1000_0062, 1'b0);

    // Misaligned branch target
    bus.br_valid = 1'b1;
    bus.br_target = 32'h0000_0042;
    tick();
    bus.br_valid = 1'b0;
    tick();
    chk("mis_addr", bus.inst_addr, 32'h0000_0042);
    chk("mis_ce", {31'd0, bus.inst_ce}, 32'd0);
    tick();
    chk_id("mis_entry", 32'h0000_0042, 32'h0000_0000, 1'b1);
    tick();
    chk_id("mis_next", 32'h0000_0046, 32'h0000_0000, 1'b1);

    // Reset during a stall with a redirect pending
    bus.id_ready = 1'b0;
    tick();
    bus.br_valid = 1'b1;
    bus.br_target = 32'h0000_0100;
    tick();
    bus.br_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.id_ready = 1'b1;
    chk("rr_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rr_pc", bus.id_pc, 32'h0000_0000);
    chk("rr_inst", bus.id_inst, 32'h0000_0000);
    chk("rr_adel", {31'd0, bus.id_adel}, 32'd0);
    chk("rr_ce", {31'd0, bus.inst_ce}, 32'd0);
    chk("rr_addr", bus.inst_addr, 32'h0000_0000);
    tick();
    tick();
    chk_id("rr_first", 32'h0000_0000, 32'h1000_0000, 1'b0);
    tick();
    chk_id("rr_second", 32'h0000_0004, 32'h1000_0001, 1'b0);

    // PC wrap at the top of the address space
    bus.flush = 1'b1;
    bus.flush_pc = 32'hFFFF_FFFC;
    tick();
    bus.flush = 1'b0;
    tick();
    chk_id("wrap_top", 32'hFFFF_FFFC, 32'h4FFF_FFFF, 1'b0);
    chk("wrap_addr", bus.inst_addr, 32'h0000_0000);
    tick();
    chk_id("wrap_zero", 32'h0000_0000, 32'h1000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
